// File: rtl/rd_sched_pkg.sv
// Shared definitions for the weighted round-robin read scheduler:
// descriptor layout, FSM state type and cell-count decoding.
package rd_sched_pkg;

    localparam int DESC_W   = 20;
    localparam int ADDR_LSB = 7;
    localparam int CNT_W    = 7;
    localparam int ADDR_W   = DESC_W - ADDR_LSB;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    // A zero cell count stands for the maximum frame of 128 cells, so the
    // decoded count is one bit wider and its MSB is set only for that case.
    function automatic logic [CNT_W:0] cnt_decode(input logic [CNT_W-1:0] cnt);
        return {(cnt == '0), cnt};
    endfunction

endpackage

// File: rtl/rd_wrr_arb.sv
// Combinational weighted round-robin winner selection. Picks the first
// eligible (non-empty, credit > 0) queue from rr_ptr upward; when no
// non-empty queue has credit it flags a reload and picks the first
// non-empty queue instead.
module rd_wrr_arb
    import rd_sched_pkg::*;
#(
    parameter int N_QUEUES = 4,
    parameter int W_BITS   = 4,
    parameter int QID_W    = $clog2(N_QUEUES)
) (
    input  logic [N_QUEUES-1:0]        empty,
    input  logic [N_QUEUES*W_BITS-1:0] credit,
    input  logic [QID_W-1:0]           rr_ptr,
    output logic                       valid,
    output logic                       reload,
    output logic [QID_W-1:0]           winner
);

    logic [N_QUEUES-1:0] eligible;
    logic [N_QUEUES-1:0] candidate;

    // A queue is eligible only while it holds data and still has credit left.
    always_comb begin
        eligible = '0;
        for (int q = 0; q < N_QUEUES; q++) begin
            eligible[q] = !empty[q] && (credit[q*W_BITS +: W_BITS] != '0);
        end
    end

    assign valid     = (empty != '1);
    assign reload    = valid && (eligible == '0);
    assign candidate = reload ? ~empty : eligible;

    // Rotating priority scan starting at rr_ptr, wrapping modulo N_QUEUES.
    always_comb begin
        int   idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_QUEUES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_QUEUES) begin
                idx = idx - N_QUEUES;
            end
            if (!found && candidate[idx]) begin
                winner = QID_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rd_sched_wrr.sv
// Per-egress-port read scheduler: pops one descriptor per frame from the
// queue chosen by weighted round robin, then issues the frame's cell reads
// one at a time with a req/gnt handshake before arbitrating again.
module rd_sched_wrr
    import rd_sched_pkg::*;
#(
    parameter int N_QUEUES = 4,
    parameter int W_BITS   = 4,
    parameter int QID_W    = $clog2(N_QUEUES)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cfg_en_i,
    input  logic [N_QUEUES*W_BITS-1:0]   cfg_weight_i,
    input  logic [N_QUEUES-1:0]          q_empty_i,
    input  logic [N_QUEUES*DESC_W-1:0]   q_data_i,
    output logic [N_QUEUES-1:0]          q_pop_o,
    output logic                         rd_req_o,
    output logic [ADDR_W-1:0]            rd_addr_o,
    output logic [QID_W-1:0]             rd_qid_o,
    output logic                         rd_last_o,
    input  logic                         rd_gnt_i,
    output logic                         busy_o
);

    state_t                     state;
    logic [W_BITS-1:0]          credit      [N_QUEUES];
    logic [W_BITS-1:0]          credit_next [N_QUEUES];
    logic [W_BITS-1:0]          weight_eff  [N_QUEUES];
    logic [N_QUEUES*W_BITS-1:0] credit_flat;
    logic [QID_W-1:0]           rr_ptr;
    logic [QID_W-1:0]           rr_next;
    logic [ADDR_W-1:0]          addr;
    logic [CNT_W:0]             remaining;
    logic [QID_W-1:0]           qid;
    logic                       arb_valid;
    logic                       arb_reload;
    logic [QID_W-1:0]           winner;
    logic                       start_frame;
    logic [DESC_W-1:0]          desc;

    rd_wrr_arb #(
        .N_QUEUES (N_QUEUES),
        .W_BITS   (W_BITS),
        .QID_W    (QID_W)
    ) u_arb (
        .empty  (q_empty_i),
        .credit (credit_flat),
        .rr_ptr (rr_ptr),
        .valid  (arb_valid),
        .reload (arb_reload),
        .winner (winner)
    );

    // Flatten credits for the arbiter and treat a zero weight as one.
    always_comb begin
        credit_flat = '0;
        for (int q = 0; q < N_QUEUES; q++) begin
            credit_flat[q*W_BITS +: W_BITS] = credit[q];
            weight_eff[q] = (cfg_weight_i[q*W_BITS +: W_BITS] == '0)
                          ? W_BITS'(1) : cfg_weight_i[q*W_BITS +: W_BITS];
        end
    end

    assign start_frame = (state == S_IDLE) && cfg_en_i && arb_valid;
    assign desc        = q_data_i[int'(winner)*DESC_W +: DESC_W];

    // Credits after a grant: reload first if needed, then charge the winner.
    always_comb begin
        for (int q = 0; q < N_QUEUES; q++) begin
            credit_next[q] = arb_reload ? weight_eff[q] : credit[q];
            if (q == int'(winner)) begin
                credit_next[q] = credit_next[q] - 1'b1;
            end
        end
        if (credit_next[winner] == '0) begin
            rr_next = (winner == QID_W'(N_QUEUES - 1)) ? '0 : winner + 1'b1;
        end else begin
            rr_next = winner;
        end
    end

    // Pop strobe is one-hot on the winner and forced low while in reset.
    always_comb begin
        q_pop_o = '0;
        if (start_frame && rst_ni) begin
            q_pop_o[winner] = 1'b1;
        end
    end

    // Frame sequencing: latch the popped descriptor, then walk its cells.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            credit    <= '{default: '0};
            addr      <= '0;
            remaining <= '0;
            qid       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_frame) begin
                        addr      <= desc[DESC_W-1:ADDR_LSB];
                        remaining <= cnt_decode(desc[CNT_W-1:0]);
                        qid       <= winner;
                        credit    <= credit_next;
                        rr_ptr    <= rr_next;
                        state     <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_gnt_i) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == (CNT_W+1)'(1)) begin
                            state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign rd_req_o  = (state == S_READ);
    assign busy_o    = (state == S_READ);
    assign rd_addr_o = addr;
    assign rd_qid_o  = qid;
    assign rd_last_o = (state == S_READ) && (remaining == (CNT_W+1)'(1));

endmodule

// File: tb/tb_rd_sched_wrr.sv
// Directed self-checking bench for rd_sched_wrr. Inputs change and outputs
// are sampled just after the falling clock edge, away from the active edge.
module tb_rd_sched_wrr;

    logic        clk;
    logic        rst_n;
    logic        cfg_en;
    logic [15:0] cfg_weight;
    logic [3:0]  q_empty;
    logic [79:0] q_data;
    logic [3:0]  q_pop;
    logic        rd_req;
    logic [12:0] rd_addr;
    logic [1:0]  rd_qid;
    logic        rd_last;
    logic        rd_gnt;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    rd_sched_wrr dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_en_i     (cfg_en),
        .cfg_weight_i (cfg_weight),
        .q_empty_i    (q_empty),
        .q_data_i     (q_data),
        .q_pop_o      (q_pop),
        .rd_req_o     (rd_req),
        .rd_addr_o    (rd_addr),
        .rd_qid_o     (rd_qid),
        .rd_last_o    (rd_last),
        .rd_gnt_i     (rd_gnt),
        .busy_o       (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] mk_desc(input logic [12:0] a, input logic [6:0] c);
        return {a, c};
    endfunction

    // Pulse reset and return just after a falling edge with safe idle inputs.
    task automatic do_reset();
        rst_n      = 1'b0;
        cfg_en     = 1'b0;
        rd_gnt     = 1'b0;
        q_empty    = 4'hF;
        q_data     = '0;
        cfg_weight = 16'h1111;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Outputs must be zero while reset is held, even with work pending.
    task automatic test_reset();
        rst_n      = 1'b0;
        cfg_en     = 1'b1;
        rd_gnt     = 1'b1;
        cfg_weight = 16'h1111;
        q_empty    = 4'b0000;
        q_data     = {4{mk_desc(13'h0AA, 7'd2)}};
        @(negedge clk);
        #1;
        checks++;
        if (q_pop !== 4'b0000) begin failures++; $display("[TB] FAIL reset_pop got=%b exp=0000", q_pop); end
        checks++;
        if ({rd_req, rd_last, busy} !== 3'b000) begin failures++; $display("[TB] FAIL reset_ctrl got=%b exp=000", {rd_req, rd_last, busy}); end
        checks++;
        if ({rd_addr, rd_qid} !== 15'h0) begin failures++; $display("[TB] FAIL reset_addr_qid got=%h exp=0", {rd_addr, rd_qid}); end
    endtask

    // One 3-cell frame from q0 with the grant held high.
    task automatic test_single_frame();
        logic [12:0] exp_addr [3];
        exp_addr = '{13'h100, 13'h101, 13'h102};
        do_reset();
        cfg_en = 1'b1;
        rd_gnt = 1'b1;
        q_empty = 4'b1110;
        q_data[19:0] = mk_desc(13'h100, 7'd3);
        #1;
        checks++;
        if (q_pop !== 4'b0001) begin failures++; $display("[TB] FAIL single_pop got=%b exp=0001", q_pop); end
        @(negedge clk);
        q_empty = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({rd_req, busy, rd_last} !== {2'b11, (i == 2)}) begin
                failures++;
                $display("[TB] FAIL single_ctrl cell=%0d got=%b exp=%b", i, {rd_req, busy, rd_last}, {2'b11, (i == 2)});
            end
            checks++;
            if (rd_addr !== exp_addr[i] || rd_qid !== 2'd0) begin
                failures++;
                $display("[TB] FAIL single_addr cell=%0d got=%h/%0d exp=%h/0", i, rd_addr, rd_qid, exp_addr[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({rd_req, busy, rd_last, q_pop} !== 7'b0) begin failures++; $display("[TB] FAIL single_end got=%b exp=0000000", {rd_req, busy, rd_last, q_pop}); end
    endtask

    // Address and last flag must hold while the grant is withheld.
    task automatic test_backpressure();
        logic        gnt_pat  [5];
        logic [12:0] exp_addr [5];
        logic        exp_last [5];
        int          grants;
        gnt_pat  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_addr = '{13'h200, 13'h200, 13'h200, 13'h201, 13'h201};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        grants   = 0;
        do_reset();
        cfg_en = 1'b1;
        q_empty = 4'b1110;
        q_data[19:0] = mk_desc(13'h200, 7'd2);
        @(negedge clk);
        q_empty = 4'hF;
        for (int i = 0; i < 5; i++) begin
            rd_gnt = gnt_pat[i];
            #1;
            checks++;
            if (rd_req !== 1'b1 || rd_addr !== exp_addr[i] || rd_last !== exp_last[i]) begin
                failures++;
                $display("[TB] FAIL bp_cycle%0d got req=%b addr=%h last=%b exp req=1 addr=%h last=%b",
                         i, rd_req, rd_addr, rd_last, exp_addr[i], exp_last[i]);
            end
            if (rd_req && rd_gnt) grants++;
            @(negedge clk);
        end
        rd_gnt = 1'b0;
        #1;
        checks++;
        if (grants !== 2 || rd_req !== 1'b0) begin failures++; $display("[TB] FAIL bp_grants got=%0d req=%b exp=2 req=0", grants, rd_req); end
    endtask

    // Weighted service order with every queue kept non-empty.
    task automatic test_wrr();
        int exp_q [7];
        exp_q = '{0, 0, 0, 1, 2, 3, 3};
        do_reset();
        cfg_weight = 16'h2013;
        cfg_en     = 1'b1;
        rd_gnt     = 1'b1;
        q_empty    = 4'b0000;
        for (int q = 0; q < 4; q++) q_data[q*20 +: 20] = mk_desc(13'(q * 16), 7'd1);
        for (int f = 0; f < 14; f++) begin
            #1;
            checks++;
            if (q_pop !== 4'(1 << exp_q[f % 7])) begin
                failures++;
                $display("[TB] FAIL wrr_pop frame=%0d got=%b exp=%b", f, q_pop, 4'(1 << exp_q[f % 7]));
            end
            @(negedge clk);
            #1;
            checks++;
            if (rd_req !== 1'b1 || rd_last !== 1'b1 || rd_qid !== 2'(exp_q[f % 7])) begin
                failures++;
                $display("[TB] FAIL wrr_read frame=%0d got req=%b last=%b qid=%0d exp req=1 last=1 qid=%0d",
                         f, rd_req, rd_last, rd_qid, exp_q[f % 7]);
            end
            @(negedge clk);
        end
    endtask

    // Count 0 means 128 cells, and the address wraps past 0x1FFF.
    task automatic test_edge();
        logic [12:0] exp_addr;
        do_reset();
        cfg_en = 1'b1;
        rd_gnt = 1'b1;
        q_empty = 4'b1110;
        q_data[19:0] = mk_desc(13'h1FFF, 7'd0);
        @(negedge clk);
        q_empty = 4'hF;
        exp_addr = 13'h1FFF;
        for (int i = 0; i < 128; i++) begin
            #1;
            checks++;
            if (rd_req !== 1'b1 || rd_addr !== exp_addr || rd_last !== (i == 127)) begin
                failures++;
                $display("[TB] FAIL edge_cell%0d got req=%b addr=%h last=%b exp req=1 addr=%h last=%b",
                         i, rd_req, rd_addr, rd_last, exp_addr, (i == 127));
            end
            exp_addr = exp_addr + 13'd1;
            @(negedge clk);
        end
        #1;
        checks++;
        if (rd_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL edge_end got req=%b busy=%b exp 0/0", rd_req, busy); end
    endtask

    // Enable gates only new pops; an empty set of queues never pops.
    task automatic test_enable();
        do_reset();
        rd_gnt  = 1'b1;
        q_empty = 4'b1101;
        q_data[39:20] = mk_desc(13'h040, 7'd3);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (q_pop !== 4'b0000 || busy !== 1'b0) begin failures++; $display("[TB] FAIL en_off_c%0d got pop=%b busy=%b exp 0000/0", i, q_pop, busy); end
            @(negedge clk);
        end
        cfg_en = 1'b1;
        #1;
        checks++;
        if (q_pop !== 4'b0010) begin failures++; $display("[TB] FAIL en_on_pop got=%b exp=0010", q_pop); end
        @(negedge clk);
        cfg_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || rd_qid !== 2'd1 || rd_addr !== 13'(13'h040 + i) || q_pop !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL en_drop_c%0d got busy=%b qid=%0d addr=%h pop=%b exp 1/1/%h/0000",
                         i, busy, rd_qid, rd_addr, q_pop, 13'(13'h040 + i));
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (q_pop !== 4'b0000 || busy !== 1'b0) begin failures++; $display("[TB] FAIL en_after_c%0d got pop=%b busy=%b exp 0000/0", i, q_pop, busy); end
            @(negedge clk);
        end
        cfg_en  = 1'b1;
        q_empty = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (q_pop !== 4'b0000 || busy !== 1'b0) begin failures++; $display("[TB] FAIL all_empty_c%0d got pop=%b busy=%b exp 0000/0", i, q_pop, busy); end
            @(negedge clk);
        end
    endtask

    // Async reset during a frame drops it; afterwards arbitration restarts
    // from q0 with fresh credits.
    task automatic test_reset_mid_frame();
        do_reset();
        cfg_en  = 1'b1;
        rd_gnt  = 1'b1;
        q_empty = 4'b0000;
        for (int q = 0; q < 4; q++) q_data[q*20 +: 20] = mk_desc(13'(13'h300 + q * 16), 7'd5);
        #1;
        checks++;
        if (q_pop !== 4'b0001) begin failures++; $display("[TB] FAIL mid_first_pop got=%b exp=0001", q_pop); end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (rd_addr !== 13'h301 || rd_req !== 1'b1) begin failures++; $display("[TB] FAIL mid_second_cell got addr=%h req=%b exp 301/1", rd_addr, rd_req); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({q_pop, rd_req, rd_addr, rd_qid, rd_last, busy} !== 22'h0) begin
            failures++;
            $display("[TB] FAIL mid_async_zero got pop=%b req=%b addr=%h qid=%0d last=%b busy=%b exp all 0",
                     q_pop, rd_req, rd_addr, rd_qid, rd_last, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (q_pop !== 4'b0001) begin failures++; $display("[TB] FAIL mid_restart_pop got=%b exp=0001", q_pop); end
        @(negedge clk);
        #1;
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== 13'h300 || rd_qid !== 2'd0) begin
            failures++;
            $display("[TB] FAIL mid_restart_read got req=%b addr=%h qid=%0d exp 1/300/0", rd_req, rd_addr, rd_qid);
        end
    endtask

    // Run every scenario in order and report.
    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_wrr();
        test_edge();
        test_enable();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rd_sched_wrr.md
Name: rd_sched_wrr

Overview:
- Per-egress-port read scheduler for the switch read path.
- Arbitrates across N_QUEUES priority descriptor FIFOs (20-bit descriptors, non-fall-through FIFOs) using weighted round robin.
- Pops one descriptor per frame, then sequences the frame's cell reads to the packet buffer with a req/gnt handshake.
- Does not start the next frame until the last cell of the current frame is granted.

Parameters:
- N_QUEUES, 4, number of queue FIFOs (2..8); QID_W = $clog2(N_QUEUES).
- W_BITS, 4, width of each per-queue weight.
- ADDR_W, 13, cell address width; fixed by descriptor format.
- CNT_W, 7, cell-count width; fixed by descriptor format.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- cfg_en_i  in  1  scheduler enable.
- cfg_weight_i  in  N_QUEUES*W_BITS  per-queue weight; queue q at [q*W_BITS +: W_BITS].
- q_empty_i  in  N_QUEUES  FIFO empty flags.
- q_data_i  in  N_QUEUES*20  FIFO heads; queue q at [q*20 +: 20].
- q_pop_o  out  N_QUEUES  one-hot pop strobe.
- rd_req_o  out  1  cell read request.
- rd_addr_o  out  ADDR_W  cell address.
- rd_qid_o  out  QID_W  queue that owns the current frame.
- rd_last_o  out  1  current request is the frame's last cell.
- rd_gnt_i  in  1  buffer accepts the request this cycle.
- busy_o  out  1  frame in progress (READ state).

Behaviour:
- Descriptor fields:
  - [19:7] is the start cell address.
  - [6:0] is the cell count; 0 encodes 128.
- Reset values:
  - Outputs: q_pop_o=0, rd_req_o=0, rd_addr_o=0, rd_qid_o=0, rd_last_o=0, busy_o=0.
  - Internal: state=IDLE, rr_ptr=0, all credits=0.
- FSM has two states, IDLE and READ.
- IDLE:
  - Arbitrate only when cfg_en_i=1 and any q_empty_i bit is 0.
  - Assert q_pop_o[w] combinationally in that same cycle for exactly one cycle.
  - Latch q_data_i[w] on that edge.
  - Load addr := desc[19:7], remaining := desc[6:0] (0 maps to 128), rd_qid_o := w.
  - Next state is READ.
- READ:
  - rd_req_o=1; rd_addr_o and rd_qid_o are held stable until rd_gnt_i.
  - rd_last_o = (remaining==1).
  - On rd_gnt_i: addr += 1, wrapping modulo 2^ADDR_W, and remaining -= 1.
  - If rd_gnt_i and remaining==1, go to IDLE; arbitration for the next frame happens in the following cycle.
  - Latency: pop at cycle t, first rd_req_o at t+1.
  - Back-to-back frames: last gnt at t, next pop at t+1.
- WRR selection (combinational in IDLE):
  - Eligible queue: non-empty and credit>0.
  - Winner is the first eligible queue scanning from rr_ptr upward, modulo N_QUEUES.
  - If no non-empty queue has credit>0, all credits reload from the weights and the winner is the first non-empty queue from rr_ptr, in the same cycle.
  - A weight of 0 is treated as 1.
- Credit update on grant:
  - credit[w] -= 1, applied after any reload.
  - If the resulting credit is 0, rr_ptr := (w+1) mod N_QUEUES; otherwise rr_ptr := w.
- cfg_en_i:
  - Deassertion blocks only new pops; a frame in READ runs to completion.
  - Weight changes take effect at the next reload.
- Pop safety: q_pop_o is never asserted for an empty queue. Popping q_empty_i=1 is an error.
- Reset asserted mid-frame: immediate return to IDLE with all outputs zero. Remaining cells are dropped and the descriptor is not re-queued.

Decomposition:
- Shared package rd_sched_pkg holds:
  - descriptor width and field offsets (DESC_W=20, ADDR_LSB=7, CNT_W=7);
  - the state enum;
  - helper function cnt_decode, mapping 0 to 128.
- One sub-module, rd_wrr_arb: a combinational winner/reload/valid computation from empty, credits and rr_ptr. Credit and pointer registers stay in the top level.

Test Plan:
- Single frame: weights=1 each; q0 desc {addr=0x0100,cnt=3} with gnt always 1 -> q_pop_o=4'b0001 at t; rd_req_o at t+1..t+3 with addr 0x100,0x101,0x102; rd_last_o at t+3; busy_o falls at t+4.
- Backpressure: cnt=2, gnt pattern 0,0,1,0,1 -> rd_addr_o holds each value while gnt=0; exactly 2 grants; rd_last_o high only with the second address.
- WRR ratio: weights {q0=3,q1=1,q2=0,q3=2}, all queues kept non-empty, cnt=1 -> service order q0,q0,q0,q1,q2,q3,q3, then repeats.
- Edge values: desc {addr=0x1FFF,cnt=0} -> 128 requests; addresses 0x1FFF,0x0000..0x007E; rd_last_o on 0x007E.
- Enable/empty: cfg_en_i=0 with q1 non-empty -> no pop. cfg_en_i dropped mid-frame -> frame completes with no further pop. All queues empty -> q_pop_o stays 0.
- Reset mid-frame: rst_ni low during the 2nd cell of cnt=5 -> all outputs 0 asynchronously. After release, the next frame pops from rr_ptr=0 with credits reloaded.
